// File: rtl/pid_chn_scheduler_pkg.sv
// Shared definitions for the PID channel scheduler: FSM encoding and default sizes.
package pid_chn_scheduler_pkg;

  localparam int unsigned DefDataWidth  = 16;
  localparam int unsigned DefNumChn     = 4;
  localparam int unsigned DefTimeoutCyc = 256;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWaitU = 2'd2
  } state_e;

  function automatic int unsigned chn_width(input int unsigned num_chn);
    return (num_chn > 1) ? $clog2(num_chn) : 1;
  endfunction

endpackage

// File: rtl/pid_chn_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester strictly after ptr_i.
module pid_chn_scheduler_rr_arbiter
  import pid_chn_scheduler_pkg::*;
#(
  parameter int unsigned NUM_CHN   = DefNumChn,
  parameter int unsigned CHN_WIDTH = chn_width(NUM_CHN)
) (
  input  logic [NUM_CHN-1:0]   req_i,
  input  logic [CHN_WIDTH-1:0] ptr_i,
  output logic [NUM_CHN-1:0]   gnt_o,
  output logic [CHN_WIDTH-1:0] gnt_idx_o,
  output logic                 gnt_valid_o
);

  int unsigned          idx;
  logic [CHN_WIDTH-1:0] idx_c;
  logic                 found;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = 0;
    idx_c     = '0;
    // Offsets 1..NUM_CHN so the previous winner is considered last.
    for (int unsigned i = 1; i <= NUM_CHN; i++) begin
      idx = 32'(ptr_i) + i;
      if (idx >= NUM_CHN) begin
        idx = idx - NUM_CHN;
      end
      idx_c = CHN_WIDTH'(idx);
      if (!found && req_i[idx_c]) begin
        found        = 1'b1;
        gnt_o[idx_c] = 1'b1;
        gnt_idx_o    = idx_c;
      end
    end
  end

  assign gnt_valid_o = |req_i;

endmodule

// File: rtl/pid_chn_scheduler.sv
// Time-shares one PID core between NUM_CHN channels: sample capture, reference
// registers, and a one-job-outstanding issue FSM with result timeout.
module pid_chn_scheduler
  import pid_chn_scheduler_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DefDataWidth,
  parameter int unsigned NUM_CHN     = DefNumChn,
  parameter int unsigned CHN_WIDTH   = chn_width(NUM_CHN),
  parameter int unsigned TIMEOUT_CYC = DefTimeoutCyc
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_CHN-1:0]            rpm_valid_i,
  input  logic [NUM_CHN*DATA_WIDTH-1:0] rpm_data_i,
  input  logic                          ref_wr_i,
  input  logic [CHN_WIDTH-1:0]          ref_chn_i,
  input  logic [DATA_WIDTH-1:0]         ref_data_i,
  output logic                          data_valid_o,
  output logic [CHN_WIDTH-1:0]          data_chn_o,
  output logic [DATA_WIDTH-1:0]         data_fdb_o,
  output logic [DATA_WIDTH-1:0]         data_ref_o,
  input  logic                          tready_i,
  input  logic                          u_valid_i,
  input  logic [CHN_WIDTH-1:0]          u_chn_i,
  output logic                          busy_o,
  output logic [NUM_CHN-1:0]            overrun_o,
  output logic                          timeout_o
);

  localparam int unsigned TimerW = $clog2(TIMEOUT_CYC + 1);

  state_e                 state_q, state_d;
  logic                   valid_q, valid_d;
  logic [CHN_WIDTH-1:0]   chn_q, chn_d;
  logic [DATA_WIDTH-1:0]  fdb_q, fdb_d;
  logic [DATA_WIDTH-1:0]  ref_out_q, ref_out_d;
  logic [TimerW-1:0]      timer_q, timer_d;
  logic                   timeout_q, timeout_d;
  logic [CHN_WIDTH-1:0]   ptr_q, ptr_d;
  logic [NUM_CHN-1:0]     pending_q, pending_d;
  logic [NUM_CHN-1:0]     overrun_q, overrun_d;
  logic [DATA_WIDTH-1:0]  fdb_buf_q [NUM_CHN];
  logic [DATA_WIDTH-1:0]  ref_q [NUM_CHN];

  logic [NUM_CHN-1:0]     gnt_oh;
  logic [CHN_WIDTH-1:0]   gnt_idx;
  logic                   gnt_valid;
  logic [NUM_CHN-1:0]     grant_clr;

  pid_chn_scheduler_rr_arbiter #(
    .NUM_CHN   (NUM_CHN),
    .CHN_WIDTH (CHN_WIDTH)
  ) u_arb (
    .req_i       (pending_q),
    .ptr_i       (ptr_q),
    .gnt_o       (gnt_oh),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_valid)
  );

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    chn_d     = chn_q;
    fdb_d     = fdb_q;
    ref_out_d = ref_out_q;
    timer_d   = timer_q;
    timeout_d = 1'b0;
    ptr_d     = ptr_q;
    grant_clr = '0;
    unique case (state_q)
      StIdle: begin
        if (gnt_valid) begin
          valid_d   = 1'b1;
          chn_d     = gnt_idx;
          fdb_d     = fdb_buf_q[gnt_idx];
          ref_out_d = ref_q[gnt_idx];
          ptr_d     = gnt_idx;
          grant_clr = gnt_oh;
          state_d   = StIssue;
        end
      end
      StIssue: begin
        if (tready_i) begin
          valid_d = 1'b0;
          timer_d = '0;
          state_d = StWaitU;
        end
      end
      StWaitU: begin
        timer_d = timer_q + TimerW'(1);
        if (u_valid_i && (u_chn_i == chn_q)) begin
          state_d = StIdle;
        end else if (timer_q == TimerW'(TIMEOUT_CYC - 1)) begin
          timeout_d = 1'b1;
          state_d   = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        valid_d = 1'b0;
      end
    endcase
    // A strobe landing on the grant edge re-arms pending; the old buffer is what issues.
    pending_d = (pending_q & ~grant_clr) | rpm_valid_i;
    overrun_d = overrun_q | (rpm_valid_i & pending_q & ~grant_clr);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      valid_q   <= 1'b0;
      chn_q     <= '0;
      fdb_q     <= '0;
      ref_out_q <= '0;
      timer_q   <= '0;
      timeout_q <= 1'b0;
      ptr_q     <= CHN_WIDTH'(NUM_CHN - 1);
      pending_q <= '0;
      overrun_q <= '0;
      for (int unsigned c = 0; c < NUM_CHN; c++) begin
        fdb_buf_q[c] <= '0;
        ref_q[c]     <= '0;
      end
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      chn_q     <= chn_d;
      fdb_q     <= fdb_d;
      ref_out_q <= ref_out_d;
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
      ptr_q     <= ptr_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      for (int unsigned c = 0; c < NUM_CHN; c++) begin
        if (rpm_valid_i[c]) begin
          fdb_buf_q[c] <= rpm_data_i[c*DATA_WIDTH +: DATA_WIDTH];
        end
        // Out-of-range channel indices match no entry and are dropped.
        if (ref_wr_i && (32'(ref_chn_i) == c)) begin
          ref_q[c] <= ref_data_i;
        end
      end
    end
  end

  assign data_valid_o = valid_q;
  assign data_chn_o   = chn_q;
  assign data_fdb_o   = fdb_q;
  assign data_ref_o   = ref_out_q;
  assign busy_o       = (state_q != StIdle);
  assign overrun_o    = overrun_q;
  assign timeout_o    = timeout_q;

endmodule
